// File: rtl/multisim_arb_pkg.sv
// Shared types and limits for the multisim channel arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package multisim_arb_pkg;

  localparam int MAX_N_REQ = 16;
  localparam int MAX_BURST = 255;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Index width for a requester count, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multisim_arbiter_rr_picker.sv
// Round-robin search: first set request at or after ptr, wrapping modulo N_REQ.
// Latency: purely combinational.
// Backpressure: none; caller decides when to act on the result.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Walk candidates ptr, ptr+1, ... and latch onto the first requester seen.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/multisim_arbiter.sv
// Round-robin burst arbiter funnelling N_REQ requesters into one multisim channel.
// Latency: 1 cycle from accepted requester beat to out_vld; one idle bubble per grant change.
// Backpressure: owner's req_rdy drops while the output slot is full and out_rdy is low.
module multisim_arbiter
  import multisim_arb_pkg::*;
#(
  parameter int  N_REQ      = 4,
  parameter int  DATA_WIDTH = 64,
  parameter int  BURST_LEN  = 4,
  localparam int IDX_W      = idx_width(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_vld,
  output logic [N_REQ-1:0]            req_rdy,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic                        out_vld,
  input  logic                        out_rdy,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [IDX_W-1:0]            out_idx,
  output logic                        busy
);

  state_t                  state;
  state_t                  state_nxt;
  logic [IDX_W-1:0]        owner;
  logic [IDX_W-1:0]        ptr;
  logic [IDX_W-1:0]        owner_inc;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_found;
  logic [7:0]              beat_cnt;
  logic                    owner_vld;
  logic                    owner_rdy;
  logic                    xfer;
  logic                    last_beat;
  logic [DATA_WIDTH-1:0]   owner_data;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (req_vld),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Owner-side handshake terms and the wrap-around successor of the owner.
  always_comb begin
    owner_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner == IDX_W'(i)) owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
    owner_vld = req_vld[owner];
    owner_rdy = (state == OWN) && (!out_vld || out_rdy);
    xfer      = owner_vld && owner_rdy;
    last_beat = (beat_cnt + 8'd1) == 8'(BURST_LEN);
    owner_inc = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: grab a grant when anyone asks; release on burst end or owner going quiet.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pick_found) state_nxt = OWN;
      OWN:  if (!owner_vld || (xfer && last_beat)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: only the owner may see ready, and only outside IDLE.
  always_comb begin
    req_rdy        = '0;
    req_rdy[owner] = owner_rdy;
    busy           = (state == OWN) || out_vld;
  end

  // Grant bookkeeping: owner capture, beat counting, fairness pointer advance on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner    <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else if (state == IDLE) begin
      if (pick_found) begin
        owner    <= pick_idx;
        beat_cnt <= '0;
      end
    end else begin
      if (xfer) beat_cnt <= beat_cnt + 8'd1;
      if (state_nxt == IDLE) ptr <= owner_inc;
    end
  end

  // Single-entry output slot: load wins over drain so back-to-back beats flow at full rate.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_idx  <= '0;
    end else if (xfer) begin
      out_vld  <= 1'b1;
      out_data <= owner_data;
      out_idx  <= owner;
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multisim_arbiter.sv
// Directed and randomized checks for the multisim channel arbiter.
// Latency: bench drives at posedge+1 and samples after inputs settle.
// Backpressure: exercised through out_rdy stalls and random out_rdy.
module tb_multisim_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_vld;
  logic [N-1:0]  req_rdy;
  logic [N*DW-1:0] req_data;
  logic          out_vld;
  logic          out_rdy;
  logic [DW-1:0] out_data;
  logic [1:0]    out_idx;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;

  multisim_arbiter #(
    .N_REQ      (N),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_rdy  (req_rdy),
    .req_data (req_data),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_idx  (out_idx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put_data(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  task automatic do_reset;
    rst      = 1'b1;
    req_vld  = '0;
    out_rdy  = 1'b1;
    req_data = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    req_vld  = 4'hF;
    out_rdy  = 1'b0;
    req_data = '1;
    tick();
    tick();
    vectors++; if (req_rdy !== 4'b0000) begin miscompares++; $display("FAIL reset_req_rdy got %b want 0000", req_rdy); end
    vectors++; if (out_vld !== 1'b0) begin miscompares++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
    vectors++; if (out_data !== 64'd0) begin miscompares++; $display("FAIL reset_out_data got %h want 0", out_data); end
    vectors++; if (out_idx !== 2'd0) begin miscompares++; $display("FAIL reset_out_idx got %0d want 0", out_idx); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    rst     = 1'b0;
    req_vld = '0;
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_round_robin;
    logic [14:0] ev;
    int          ei[15];
    ev = 15'b111101111011110;
    ei = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 2, 2, 2, 2};
    do_reset();
    for (int i = 0; i < N; i++) put_data(i, 64'hC0DE_0000_0000_0000 | 64'(i));
    req_vld = 4'hF;
    for (int k = 1; k <= 15; k++) begin
      tick();
      vectors++;
      if (out_vld !== ev[k-1]) begin
        miscompares++; $display("FAIL rr_vld cycle %0d got %b want %b", k, out_vld, ev[k-1]);
      end
      if (ev[k-1]) begin
        vectors++;
        if (out_idx !== 2'(ei[k-1]) || out_data !== (64'hC0DE_0000_0000_0000 | 64'(ei[k-1]))) begin
          miscompares++; $display("FAIL rr_idx cycle %0d got idx %0d data %h want idx %0d", k, out_idx, out_data, ei[k-1]);
        end
      end
    end
  endtask

  task automatic test_single_req(input bit follow);
    logic [3:0] want_next;
    want_next = follow ? 4'b1000 : 4'b0001;
    do_reset();
    put_data(2, 64'h2222_0000_0000_0001);
    req_vld = 4'b0100;
    tick(); // c1
    vectors++; if (req_rdy !== 4'b0100) begin miscompares++; $display("FAIL single_grant got %b want 0100", req_rdy); end
    tick(); // c2
    vectors++; if (out_vld !== 1'b1 || out_idx !== 2'd2 || out_data !== 64'h2222_0000_0000_0001) begin
      miscompares++; $display("FAIL single_beat1 got vld %b idx %0d data %h", out_vld, out_idx, out_data); end
    put_data(2, 64'h2222_0000_0000_0002);
    tick(); // c3
    vectors++; if (out_vld !== 1'b1 || out_idx !== 2'd2 || out_data !== 64'h2222_0000_0000_0002) begin
      miscompares++; $display("FAIL single_beat2 got vld %b idx %0d data %h", out_vld, out_idx, out_data); end
    put_data(2, 64'h2222_0000_0000_0003);
    tick(); // c4
    vectors++; if (out_vld !== 1'b1 || out_idx !== 2'd2 || out_data !== 64'h2222_0000_0000_0003) begin
      miscompares++; $display("FAIL single_beat3 got vld %b idx %0d data %h", out_vld, out_idx, out_data); end
    req_vld = 4'b0000;
    tick(); // c5
    vectors++; if (out_vld !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL single_release got vld %b busy %b want 0 0", out_vld, busy); end
    req_vld = follow ? 4'b1001 : 4'b0011;
    #1;
    vectors++; if (req_rdy !== 4'b0000) begin miscompares++; $display("FAIL single_idle_rdy got %b want 0000", req_rdy); end
    tick(); // c6
    vectors++; if (req_rdy !== want_next) begin
      miscompares++; $display("FAIL single_next_grant got %b want %b", req_rdy, want_next); end
  endtask

  task automatic test_backpressure;
    do_reset();
    put_data(1, 64'hBEEF_0000_0000_0001);
    req_vld = 4'b0010;
    tick(); // c1
    tick(); // c2
    vectors++; if (out_vld !== 1'b1 || out_data !== 64'hBEEF_0000_0000_0001) begin
      miscompares++; $display("FAIL bp_first got vld %b data %h", out_vld, out_data); end
    out_rdy = 1'b0;
    put_data(1, 64'hBEEF_0000_0000_0002);
    #1;
    for (int j = 0; j < 5; j++) begin
      vectors++;
      if (out_vld !== 1'b1 || out_data !== 64'hBEEF_0000_0000_0001 || out_idx !== 2'd1 || req_rdy !== 4'b0000) begin
        miscompares++; $display("FAIL bp_stall %0d got vld %b data %h rdy %b", j, out_vld, out_data, req_rdy);
      end
      tick();
    end
    vectors++; if (out_data !== 64'hBEEF_0000_0000_0001) begin
      miscompares++; $display("FAIL bp_hold got %h want beef..0001", out_data); end
    out_rdy = 1'b1;
    #1;
    vectors++; if (req_rdy !== 4'b0010) begin miscompares++; $display("FAIL bp_resume_rdy got %b want 0010", req_rdy); end
    tick(); // c8
    vectors++; if (out_vld !== 1'b1 || out_data !== 64'hBEEF_0000_0000_0002) begin
      miscompares++; $display("FAIL bp_beat2 got vld %b data %h", out_vld, out_data); end
    put_data(1, 64'hBEEF_0000_0000_0003);
    tick(); // c9
    vectors++; if (out_vld !== 1'b1 || out_data !== 64'hBEEF_0000_0000_0003) begin
      miscompares++; $display("FAIL bp_beat3 got vld %b data %h", out_vld, out_data); end
    put_data(1, 64'hBEEF_0000_0000_0004);
    tick(); // c10
    vectors++; if (out_vld !== 1'b1 || out_data !== 64'hBEEF_0000_0000_0004) begin
      miscompares++; $display("FAIL bp_beat4 got vld %b data %h", out_vld, out_data); end
    vectors++; if (req_rdy !== 4'b0000) begin miscompares++; $display("FAIL bp_burst_end_rdy got %b want 0000", req_rdy); end
    req_vld = 4'b0000;
    tick(); // c11
    vectors++; if (out_vld !== 1'b0) begin miscompares++; $display("FAIL bp_drained got %b want 0", out_vld); end
  endtask

  task automatic test_mid_reset;
    do_reset();
    for (int i = 0; i < N; i++) put_data(i, 64'hAAAA_0000_0000_0000 | 64'(i));
    req_vld = 4'hF;
    for (int k = 0; k < 8; k++) tick();
    vectors++; if (out_vld !== 1'b1 || out_idx !== 2'd1) begin
      miscompares++; $display("FAIL mid_pre got vld %b idx %0d want 1 1", out_vld, out_idx); end
    rst = 1'b1;
    tick();
    vectors++; if (out_vld !== 1'b0 || out_data !== 64'd0 || out_idx !== 2'd0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL mid_cleared got vld %b data %h idx %0d busy %b", out_vld, out_data, out_idx, busy); end
    rst = 1'b0;
    #1;
    vectors++; if (req_rdy !== 4'b0000) begin miscompares++; $display("FAIL mid_rdy got %b want 0000", req_rdy); end
    tick();
    vectors++; if (req_rdy !== 4'b0001 || out_vld !== 1'b0) begin
      miscompares++; $display("FAIL mid_regrant got rdy %b vld %b want 0001 0", req_rdy, out_vld); end
    tick();
    vectors++; if (out_vld !== 1'b1 || out_idx !== 2'd0) begin
      miscompares++; $display("FAIL mid_first_beat got vld %b idx %0d want 1 0", out_vld, out_idx); end
  endtask

  task automatic test_random;
    logic [DW-1:0] sbq[$];
    logic [DW-1:0] exp;
    logic [N-1:0]  pend;
    int            seq;
    bit            allow;
    pend = '0;
    seq  = 0;
    do_reset();
    for (int c = 0; c < 10100; c++) begin
      tick();
      allow = (c < 10000);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && allow && ($urandom_range(0, 2) != 0)) begin
          pend[i] = 1'b1;
          put_data(i, {32'(i), 32'(seq)});
          seq++;
        end
      end
      req_vld = pend;
      out_rdy = allow ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      vectors++;
      if ($countones(req_rdy) > 1) begin
        miscompares++; $display("FAIL rand_onehot cycle %0d got %b", c, req_rdy);
      end
      if (out_vld && out_rdy) begin
        vectors++;
        if (sbq.size() == 0) begin
          miscompares++; $display("FAIL rand_extra cycle %0d got %h with empty scoreboard", c, out_data);
        end else begin
          exp = sbq.pop_front();
          if (out_data !== exp || out_idx !== exp[33:32]) begin
            miscompares++; $display("FAIL rand_beat cycle %0d got idx %0d data %h want %h", c, out_idx, out_data, exp);
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_vld[i] && req_rdy[i]) begin
          sbq.push_back(req_data[i*DW +: DW]);
          pend[i] = 1'b0;
        end
      end
    end
    vectors++; if (sbq.size() != 0 || out_vld !== 1'b0 || busy !== 1'b0 || pend != '0) begin
      miscompares++; $display("FAIL rand_drain got pending %0d vld %b busy %b", sbq.size(), out_vld, busy); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_req(1'b1);
    test_single_req(1'b0);
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
